// File: rtl/calc2_port_responder_if.sv
// calc2_port_responder_if: request/response bus of the calc2 single-port responder
interface calc2_port_responder_if;
  logic [3:0] req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0] req_tag_in;
  logic [1:0] out_resp;
  logic [31:0] out_data;
  logic [1:0] out_tag;
  logic [3:0] pending;
  logic drop_err;
  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input out_resp, out_data, out_tag, pending, drop_err
  );
  modport slave (
    input req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, pending, drop_err
  );
endinterface

// File: rtl/calc2_port_responder.sv
// calc2_port_responder: two-cycle calc2 request capture with fixed-latency in-order responses
module calc2_port_responder #(
  parameter int LATENCY = 3,
  parameter int DEPTH = 4
) (
  input logic c_clk,
  input logic reset,
  calc2_port_responder_if.slave bus
);
  typedef enum logic {IDLE, OP2} state_t;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [3:0] DEP = 4'(DEPTH);
  state_t state, next_state;
  logic [3:0] cmd;
  logic [1:0] tag;
  logic [31:0] a;
  logic [1:0] q_resp [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [1:0] q_tag [DEPTH];
  logic [3:0] q_age [DEPTH];
  logic [AW-1:0] head, tail;
  logic [3:0] count;
  logic [32:0] sum;
  logic [1:0] res_code;
  logic [31:0] res_data;
  logic push, pop, accept;
  logic [1:0] o_resp, o_tag;
  logic [31:0] o_data;
  logic drop;
  always_comb begin
    next_state = state;
    next_state = (state == IDLE && bus.req_cmd_in != 4'd0) ? OP2 : IDLE;
    sum = {1'b0, a} + {1'b0, bus.req_data_in};
    res_code = cmd == 4'd1 ? (sum[32] ? 2'd2 : 2'd1) :
               cmd == 4'd2 ? (bus.req_data_in > a ? 2'd2 : 2'd1) :
               (cmd == 4'd5 || cmd == 4'd6) ? 2'd1 : 2'd3;
    res_data = cmd == 4'd1 ? sum[31:0] :
               cmd == 4'd2 ? a - bus.req_data_in :
               cmd == 4'd5 ? a << bus.req_data_in[4:0] :
               cmd == 4'd6 ? a >> bus.req_data_in[4:0] : 32'd0;
    push = state == OP2;
    pop = count != 4'd0 && q_age[head] == LAT;
    accept = push && (count < DEP || pop);
  end
  // Entries share one latency, so only the head can ever mature.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cmd <= '0;
      tag <= '0;
      a <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_resp[i] <= '0;
        q_data[i] <= '0;
        q_tag[i] <= '0;
        q_age[i] <= '0;
      end
      head <= '0;
      tail <= '0;
      count <= '0;
      o_resp <= '0;
      o_data <= '0;
      o_tag <= '0;
      drop <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.req_cmd_in != 4'd0) begin
        cmd <= bus.req_cmd_in;
        tag <= bus.req_tag_in;
        a <= bus.req_data_in;
      end
      for (int i = 0; i < DEPTH; i++) q_age[i] <= q_age[i] + 4'd1;
      if (accept) begin
        q_resp[tail] <= res_code;
        q_data[tail] <= res_data;
        q_tag[tail] <= tag;
        q_age[tail] <= 4'd1;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + {3'b0, accept} - {3'b0, pop};
      if (push && !accept) drop <= 1'b1;
      o_resp <= pop ? q_resp[head] : 2'd0;
      o_data <= pop ? q_data[head] : 32'd0;
      o_tag <= pop ? q_tag[head] : 2'd0;
    end
  end
  assign bus.out_resp = o_resp;
  assign bus.out_data = o_data;
  assign bus.out_tag = o_tag;
  assign bus.pending = count;
  assign bus.drop_err = drop;
endmodule
